// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline stall controller
//
// Purpose : FSM state encoding, default memory-wait limit, the hard-wired
//           zero register index, stage-control bundle and a register-compare
//           helper shared by the stall controller and its hazard detector.
// Ports   : none (package).

package pipe_ctrl_pkg;

    localparam int         MAX_WAIT_DEFAULT = 16;
    localparam logic [4:0] ZERO_REG         = 5'd0;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FAULT    = 2'd2
    } pipe_state_e;

    // Field order matches the bit patterns of the constants below.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic ifid_flush;
        logic idex_bubble;
        logic memwb_bubble;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_RUN      = stage_ctrl_t'(7'b1111_000);
    localparam stage_ctrl_t CTRL_BRANCH   = stage_ctrl_t'(7'b1111_100);
    // Hold PC and IF/ID, push a NOP into ID/EX; the load keeps moving.
    localparam stage_ctrl_t CTRL_LOAD_USE = stage_ctrl_t'(7'b0011_010);
    // Freeze everything upstream of MEM/WB while memory is busy.
    localparam stage_ctrl_t CTRL_MEM_HOLD = stage_ctrl_t'(7'b0000_001);
    localparam stage_ctrl_t CTRL_FAULT    = stage_ctrl_t'(7'b0000_011);
    localparam stage_ctrl_t CTRL_RESET    = stage_ctrl_t'(7'b0000_011);

    // A source register conflicts with a destination only when it is read.
    function automatic logic reg_conflict(input logic [4:0] dst,
                                          input logic [4:0] src,
                                          input logic       used);
        return used && (dst == src);
    endfunction

endpackage

// File: rtl/pipeline_stall_controller_load_use_detect.sv
// rtl/pipeline_stall_controller_load_use_detect.sv - load-use hazard comparator
//
// Purpose : flags when the instruction in IF/ID reads the destination of a
//           load currently in ID/EX. Register $0 never creates a hazard.
// Ports   : idex_mem_read/idex_rt      - load in ID/EX and its destination
//           ifid_rs/ifid_rt            - IF/ID source registers
//           ifid_uses_rs/ifid_uses_rt  - whether each source is actually read
//           load_use                   - hazard present (combinational)

module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       idex_mem_read,
    input  logic [4:0] idex_rt,
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    input  logic       ifid_uses_rs,
    input  logic       ifid_uses_rt,
    output logic       load_use
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit   = reg_conflict(idex_rt, ifid_rs, ifid_uses_rs);
    assign rt_hit   = reg_conflict(idex_rt, ifid_rt, ifid_uses_rt);
    assign load_use = idex_mem_read && (idex_rt != ZERO_REG) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - pipeline stall / flush / bubble controller
//
// Purpose : produces stage-register enables, flush and bubble controls for a
//           5-stage pipeline from load-use hazards, data-memory waits and
//           taken branches; times out a stuck memory access into a sticky
//           fault and counts stalled cycles.
// Ports   : clk, rst_n (async, active-low)
//           idex_mem_read, idex_rt, ifid_rs, ifid_rt, ifid_uses_rs,
//           ifid_uses_rt                   - hazard-detection inputs
//           branch_taken                   - branch in ID resolves taken
//           dmem_req, dmem_ready           - MEM-stage access handshake
//           perf_clr                       - synchronous clear of stall_cycles
//           pc_en, ifid_en, idex_en, exmem_en - stage advance enables
//           ifid_flush, idex_bubble, memwb_bubble - squash / NOP insertion
//           err                            - sticky memory-timeout fault
//           stall_cycles                   - saturating stall counter

module pipeline_stall_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        idex_mem_read,
    input  logic [4:0]  idex_rt,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        ifid_uses_rs,
    input  logic        ifid_uses_rt,
    input  logic        branch_taken,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    input  logic        perf_clr,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        memwb_bubble,
    output logic        err,
    output logic [15:0] stall_cycles
);

    localparam int                WAIT_W    = $clog2(MAX_WAIT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    pipe_state_e        state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0]        stall_cycles_q, stall_cycles_d;

    logic               load_use;
    logic               mem_stall;
    logic               wait_expired;
    stage_ctrl_t        ctrl;

    load_use_detect u_load_use_detect (
        .idex_mem_read (idex_mem_read),
        .idex_rt       (idex_rt),
        .ifid_rs       (ifid_rs),
        .ifid_rt       (ifid_rt),
        .ifid_uses_rs  (ifid_uses_rs),
        .ifid_uses_rt  (ifid_uses_rt),
        .load_use      (load_use)
    );

    // Ready in the same cycle as the request completes the access outright.
    assign mem_stall    = dmem_req && !dmem_ready;
    assign wait_expired = mem_stall && (wait_cnt_q == WAIT_LAST);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_RUN;
            wait_cnt_q     <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        unique case (state_q)
            ST_RUN, ST_MEM_WAIT: begin
                if (mem_stall) begin
                    state_d = wait_expired ? ST_FAULT : ST_MEM_WAIT;
                    // The counter never needs to pass WAIT_LAST: the wait
                    // either ends or the FSM leaves for FAULT.
                    if (!wait_expired) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_RUN;
        endcase
    end

    // --------------------------------------------------------------- outputs
    always_comb begin
        ctrl = CTRL_RUN;
        if (!rst_n) begin
            ctrl = CTRL_RESET;
        end else if (state_q == ST_FAULT) begin
            ctrl = CTRL_FAULT;
        end else if (mem_stall) begin
            ctrl = CTRL_MEM_HOLD;
        end else if (load_use) begin
            // A taken branch behind a load-use stall is re-presented next
            // cycle, so it is deliberately ignored here.
            ctrl = CTRL_LOAD_USE;
        end else if (branch_taken) begin
            ctrl = CTRL_BRANCH;
        end
    end

    // Stalls are counted only while the pipeline is still alive.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (perf_clr) begin
            stall_cycles_d = '0;
        end else if (!ctrl.pc_en && (state_q != ST_FAULT)
                     && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    assign pc_en        = ctrl.pc_en;
    assign ifid_en      = ctrl.ifid_en;
    assign idex_en      = ctrl.idex_en;
    assign exmem_en     = ctrl.exmem_en;
    assign ifid_flush   = ctrl.ifid_flush;
    assign idex_bubble  = ctrl.idex_bubble;
    assign memwb_bubble = ctrl.memwb_bubble;
    assign err          = (state_q == ST_FAULT);
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - self-checking bench for pipeline_stall_controller

module tb_pipeline_stall_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        idex_mem_read = 0, ifid_uses_rs = 0, ifid_uses_rt = 0;
    logic [4:0]  idex_rt = 0, ifid_rs = 0, ifid_rt = 0;
    logic        branch_taken = 0, dmem_req = 0, dmem_ready = 0, perf_clr = 0;

    logic        pc_en4, ifid_en4, idex_en4, exmem_en4, flush4, idb4, mwb4, err4;
    logic [15:0] sc4;
    logic        pc_en16, ifid_en16, idex_en16, exmem_en16, flush16, idb16, mwb16, err16;
    logic [15:0] sc16;
    logic [7:0]  o4, o16;

    assign o4  = {pc_en4, ifid_en4, idex_en4, exmem_en4, flush4, idb4, mwb4, err4};
    assign o16 = {pc_en16, ifid_en16, idex_en16, exmem_en16, flush16, idb16, mwb16, err16};

    always #5 clk = ~clk;

    pipeline_stall_controller #(.MAX_WAIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rs(ifid_uses_rs),
        .ifid_uses_rt(ifid_uses_rt), .branch_taken(branch_taken), .dmem_req(dmem_req),
        .dmem_ready(dmem_ready), .perf_clr(perf_clr), .pc_en(pc_en4), .ifid_en(ifid_en4),
        .idex_en(idex_en4), .exmem_en(exmem_en4), .ifid_flush(flush4),
        .idex_bubble(idb4), .memwb_bubble(mwb4), .err(err4), .stall_cycles(sc4)
    );

    pipeline_stall_controller dut16 (
        .clk(clk), .rst_n(rst_n), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rs(ifid_uses_rs),
        .ifid_uses_rt(ifid_uses_rt), .branch_taken(branch_taken), .dmem_req(dmem_req),
        .dmem_ready(dmem_ready), .perf_clr(perf_clr), .pc_en(pc_en16), .ifid_en(ifid_en16),
        .idex_en(idex_en16), .exmem_en(exmem_en16), .ifid_flush(flush16),
        .idex_bubble(idb16), .memwb_bubble(mwb16), .err(err16), .stall_cycles(sc16)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: a fault flag, a run length of consecutive stalled
    // cycles and a stall tally per instance.
    bit flt4, flt16;
    int consec4, consec16, tally4, tally16;

    typedef struct {
        string      name;
        logic       mr;
        logic [4:0] rt, rs, rtt;
        logic       urs, urt, br, req, rdy;
        logic [7:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected {pc,ifid,idex,exmem,flush,idex_bubble,memwb_bubble,err}.
    function automatic logic [7:0] model_out(input bit flt, input bit ms, input bit lu, input bit br);
        if (flt)      return 8'b0000_0111;
        else if (ms)  return 8'b0000_0010;
        else if (lu)  return 8'b0011_0100;
        else if (br)  return 8'b1111_1000;
        else          return 8'b1111_0000;
    endfunction

    task automatic model_step(input int m, input bit ms, input bit pc, input bit clr,
                              inout int consec, inout bit flt, inout int tally);
        if (clr)                          tally = 0;
        else if (!pc && !flt && tally < 65535) tally = tally + 1;
        if (!flt && ms && consec == m - 1) flt = 1'b1;
        consec = (ms && !flt) ? consec + 1 : 0;
    endtask

    task automatic model_reset();
        flt4 = 0; flt16 = 0; consec4 = 0; consec16 = 0; tally4 = 0; tally16 = 0;
    endtask

    // One clock: drive, check combinational outputs mid-cycle, clock, check counters.
    task automatic cycle(input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                         input logic [4:0] rtt, input logic urs, input logic urt,
                         input logic br, input logic req, input logic rdy, input logic clr,
                         input string tag);
        bit lu, ms;
        logic [7:0] e4, e16;
        idex_mem_read = mr; idex_rt = rt; ifid_rs = rs; ifid_rt = rtt;
        ifid_uses_rs = urs; ifid_uses_rt = urt; branch_taken = br;
        dmem_req = req; dmem_ready = rdy; perf_clr = clr;
        lu = mr && (rt != 0) && ((urs && rt == rs) || (urt && rt == rtt));
        ms = req && !rdy;
        e4  = model_out(flt4, ms, lu, br);
        e16 = model_out(flt16, ms, lu, br);
        #3;
        chk({tag, "_out4"}, {24'd0, o4}, {24'd0, e4});
        chk({tag, "_out16"}, {24'd0, o16}, {24'd0, e16});
        @(posedge clk);
        #1;
        model_step(4, ms, e4[7], clr, consec4, flt4, tally4);
        model_step(16, ms, e16[7], clr, consec16, flt16, tally16);
        chk({tag, "_sc4"}, {16'd0, sc4}, tally4);
        chk({tag, "_sc16"}, {16'd0, sc16}, tally16);
    endtask

    task automatic idle(input string tag);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    task automatic stall_mem(input string tag);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, tag);
    endtask

    // Reset is asserted mid-cycle so its effect is checked before any edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_out4", {24'd0, o4}, 32'h06);
        chk("rst_out16", {24'd0, o16}, 32'h06);
        chk("rst_sc4", {16'd0, sc4}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{"load_use_rs",  1, 10, 10, 0, 1, 0, 0, 0, 0, 8'b0011_0100};
        vecs[1]  = '{"zero_guard",   1,  0,  0, 0, 1, 0, 0, 0, 0, 8'b1111_0000};
        vecs[2]  = '{"lu_beats_br",  1, 10, 10, 0, 1, 0, 1, 0, 0, 8'b0011_0100};
        vecs[3]  = '{"branch_only",  0, 10, 10, 0, 1, 0, 1, 0, 0, 8'b1111_1000};
        vecs[4]  = '{"load_use_rt",  1,  7,  3, 7, 0, 1, 0, 0, 0, 8'b0011_0100};
        vecs[5]  = '{"rt_unused",    1,  7,  3, 7, 0, 0, 0, 0, 0, 8'b1111_0000};
        vecs[6]  = '{"no_load",      0,  7,  7, 7, 1, 1, 0, 0, 0, 8'b1111_0000};
        vecs[7]  = '{"req_rdy",      0,  0,  0, 0, 0, 0, 0, 1, 1, 8'b1111_0000};
        vecs[8]  = '{"req_rdy_br",   0,  0,  0, 0, 0, 0, 1, 1, 1, 8'b1111_1000};
        vecs[9]  = '{"mem_over_lu",  1, 10, 10, 0, 1, 0, 1, 1, 0, 8'b0000_0010};
        vecs[10] = '{"wait_exit_lu", 1, 10, 10, 0, 1, 0, 0, 1, 1, 8'b0011_0100};
        vecs[11] = '{"idle",         0,  0,  0, 0, 0, 0, 0, 0, 0, 8'b1111_0000};

        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Table-driven single-cycle vectors.
        for (int i = 0; i < 12; i++) begin
            cycle(vecs[i].mr, vecs[i].rt, vecs[i].rs, vecs[i].rtt, vecs[i].urs,
                  vecs[i].urt, vecs[i].br, vecs[i].req, vecs[i].rdy, 0, vecs[i].name);
            #3;
            chk({vecs[i].name, "_tbl"}, {24'd0, o4}, {24'd0, vecs[i].exp});
            // Re-drive the same inputs isn't needed; bring outputs back in line.
            #1;
            @(posedge clk);
            #1;
            model_step(4, vecs[i].req && !vecs[i].rdy, vecs[i].exp[7], 0, consec4, flt4, tally4);
            model_step(16, vecs[i].req && !vecs[i].rdy, vecs[i].exp[7], 0, consec16, flt16, tally16);
        end
        chk("tbl_sc4", {16'd0, sc4}, tally4);

        // Memory wait of three cycles, then completion.
        do_reset();
        for (int i = 0; i < 3; i++) stall_mem("memwait");
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, "memwait_done");
        chk("memwait_sc", {16'd0, sc4}, 32'd3);
        idle("memwait_run");
        chk("memwait_run_pc", {31'd0, pc_en4}, 32'd1);

        // Timeout: MAX_WAIT=4 instance faults after 4 stalls, default after 16.
        do_reset();
        for (int i = 0; i < 4; i++) stall_mem("tmo");
        chk("tmo_err4", {31'd0, err4}, 32'd1);
        chk("tmo_err16_early", {31'd0, err16}, 32'd0);
        for (int i = 0; i < 12; i++) stall_mem("tmo16");
        chk("tmo_err16", {31'd0, err16}, 32'd1);
        idle("tmo_sticky");
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, "tmo_sticky_rdy");
        chk("tmo_err4_sticky", {31'd0, err4}, 32'd1);
        do_reset();
        chk("tmo_err4_cleared", {31'd0, err4}, 32'd0);
        idle("tmo_after_reset");

        // Counter saturation via sustained load-use stalls, then clear.
        do_reset();
        for (int i = 0; i < 65540; i++) cycle(1, 10, 10, 0, 1, 0, 0, 0, 0, 0, "sat");
        chk("sat_hold", {16'd0, sc4}, 32'h0000FFFF);
        cycle(1, 10, 10, 0, 1, 0, 0, 0, 0, 1, "sat_clr");
        chk("sat_cleared", {16'd0, sc4}, 32'd0);

        // Randomized traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 1),
                      $urandom_range(0, 1), $urandom_range(0, 9) < 3, $urandom_range(0, 1),
                      $urandom_range(0, 19) == 0, "rand");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
